// File: rtl/risc_v_decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage: opcode/mnemonic
// encodings, immediate formats and the decoded-word record.
package risc_v_decode_stage_pkg;

  localparam int DEC_IMM_W = 64;
  localparam int DEC_PC_W  = 64;

  localparam logic [31:0] ENV_ECALL  = 32'h0000_0073;
  localparam logic [31:0] ENV_EBREAK = 32'h0010_0073;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } t_instr_opcode;

  typedef enum logic [5:0] {
    OP_NA = 6'd0,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_JALR, OP_ECALL, OP_EBREAK,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_LUI, OP_AUIPC
  } t_instr_mnemonic;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } t_imm_fmt;

  // imm/pc are held at their widest; the stage narrows them to XLEN/PC_W.
  typedef struct packed {
    t_instr_mnemonic        mnem;
    t_instr_opcode          opcode;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [DEC_IMM_W-1:0]   imm;
    logic                   rd_we;
    logic                   illegal;
    logic [DEC_PC_W-1:0]    pc;
  } t_decoded;

endpackage

// File: rtl/risc_v_decode_stage_if.sv
// Handshake and decoded-output bundle between fetch, decode stage and execute.
interface risc_v_decode_stage_if
  import risc_v_decode_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = 10,
  parameter int ILL_CNT_W = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [PC_W-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  t_instr_mnemonic      out_mnem;
  t_instr_opcode        out_opcode;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [XLEN-1:0]      out_imm;
  logic                 out_rd_we;
  logic                 out_illegal;
  logic [PC_W-1:0]      out_pc;
  logic [ILL_CNT_W-1:0] ill_count;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_mnem, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm, out_rd_we, out_illegal, out_pc, ill_count
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_mnem, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm, out_rd_we, out_illegal, out_pc, ill_count
  );

endinterface

// File: rtl/risc_v_decoder_comb.sv
// Purely combinational RV32I instruction decoder: raw word -> t_decoded.
// The pc field is left zero; the stage fills it in.
module risc_v_decoder_comb
  import risc_v_decode_stage_pkg::*;
#(
  parameter int SUPPORT_U = 1
) (
  input  logic [31:0] instr,
  output t_decoded    dec
);

  logic [6:0]           opc_s;
  logic [2:0]           f3_s;
  logic [6:0]           f7_s;
  logic [DEC_IMM_W-1:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s, imm_sel_s;
  t_instr_mnemonic      mnem_s;
  t_imm_fmt             fmt_s;
  logic                 wr_s;

  assign opc_s = instr[6:0];
  assign f3_s  = instr[14:12];
  assign f7_s  = instr[31:25];

  assign imm_i_s = {{52{instr[31]}}, instr[31:20]};
  assign imm_s_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j_s = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u_s = {{32{instr[31]}}, instr[31:12], 12'b0};

  // Mnemonic, immediate format and write-back intent per opcode class.
  always_comb begin
    mnem_s = OP_NA;
    fmt_s  = IMM_NONE;
    wr_s   = 1'b0;
    case (opc_s)
      OPC_OP: begin
        wr_s = 1'b1;
        case (f3_s)
          3'b000: begin
            if (f7_s == F7_BASE) begin
              mnem_s = OP_ADD;
            end else if (f7_s == F7_ALT) begin
              mnem_s = OP_SUB;
            end else begin
              mnem_s = OP_NA;
            end
          end
          3'b001: mnem_s = (f7_s == F7_BASE) ? OP_SLL  : OP_NA;
          3'b010: mnem_s = (f7_s == F7_BASE) ? OP_SLT  : OP_NA;
          3'b011: mnem_s = (f7_s == F7_BASE) ? OP_SLTU : OP_NA;
          3'b100: mnem_s = (f7_s == F7_BASE) ? OP_XOR  : OP_NA;
          3'b101: begin
            if (f7_s == F7_BASE) begin
              mnem_s = OP_SRL;
            end else if (f7_s == F7_ALT) begin
              mnem_s = OP_SRA;
            end else begin
              mnem_s = OP_NA;
            end
          end
          3'b110: mnem_s = (f7_s == F7_BASE) ? OP_OR  : OP_NA;
          3'b111: mnem_s = (f7_s == F7_BASE) ? OP_AND : OP_NA;
          default: mnem_s = OP_NA;
        endcase
      end
      OPC_OP_IMM: begin
        wr_s  = 1'b1;
        fmt_s = IMM_I;
        case (f3_s)
          3'b000: mnem_s = OP_ADDI;
          3'b010: mnem_s = OP_SLTI;
          3'b011: mnem_s = OP_SLTIU;
          3'b100: mnem_s = OP_XORI;
          3'b110: mnem_s = OP_ORI;
          3'b111: mnem_s = OP_ANDI;
          3'b001: mnem_s = (f7_s == F7_BASE) ? OP_SLLI : OP_NA;
          3'b101: begin
            if (f7_s == F7_BASE) begin
              mnem_s = OP_SRLI;
            end else if (f7_s == F7_ALT) begin
              mnem_s = OP_SRAI;
            end else begin
              mnem_s = OP_NA;
            end
          end
          default: mnem_s = OP_NA;
        endcase
      end
      OPC_LOAD: begin
        wr_s  = 1'b1;
        fmt_s = IMM_I;
        case (f3_s)
          3'b000:  mnem_s = OP_LB;
          3'b001:  mnem_s = OP_LH;
          3'b010:  mnem_s = OP_LW;
          3'b100:  mnem_s = OP_LBU;
          3'b101:  mnem_s = OP_LHU;
          default: mnem_s = OP_NA;
        endcase
      end
      OPC_JALR: begin
        wr_s   = 1'b1;
        fmt_s  = IMM_I;
        mnem_s = (f3_s == 3'b000) ? OP_JALR : OP_NA;
      end
      OPC_SYSTEM: begin
        if (instr == ENV_ECALL) begin
          mnem_s = OP_ECALL;
        end else if (instr == ENV_EBREAK) begin
          mnem_s = OP_EBREAK;
        end else begin
          mnem_s = OP_NA;
        end
      end
      OPC_STORE: begin
        fmt_s = IMM_S;
        case (f3_s)
          3'b000:  mnem_s = OP_SB;
          3'b001:  mnem_s = OP_SH;
          3'b010:  mnem_s = OP_SW;
          default: mnem_s = OP_NA;
        endcase
      end
      OPC_BRANCH: begin
        fmt_s = IMM_B;
        case (f3_s)
          3'b000:  mnem_s = OP_BEQ;
          3'b001:  mnem_s = OP_BNE;
          3'b100:  mnem_s = OP_BLT;
          3'b101:  mnem_s = OP_BGE;
          3'b110:  mnem_s = OP_BLTU;
          3'b111:  mnem_s = OP_BGEU;
          default: mnem_s = OP_NA;
        endcase
      end
      OPC_JAL: begin
        wr_s   = 1'b1;
        fmt_s  = IMM_J;
        mnem_s = OP_JAL;
      end
      OPC_LUI, OPC_AUIPC: begin
        if (SUPPORT_U != 0) begin
          wr_s   = 1'b1;
          fmt_s  = IMM_U;
          mnem_s = (opc_s == OPC_LUI) ? OP_LUI : OP_AUIPC;
        end else begin
          mnem_s = OP_NA;
        end
      end
      default: mnem_s = OP_NA;
    endcase
  end

  // Immediate selection by format.
  always_comb begin
    imm_sel_s = '0;
    case (fmt_s)
      IMM_I:   imm_sel_s = imm_i_s;
      IMM_S:   imm_sel_s = imm_s_s;
      IMM_B:   imm_sel_s = imm_b_s;
      IMM_J:   imm_sel_s = imm_j_s;
      IMM_U:   imm_sel_s = imm_u_s;
      default: imm_sel_s = '0;
    endcase
  end

  // Assemble the record; an undecodable word carries no immediate and no write-back.
  always_comb begin
    dec        = '0;
    dec.mnem   = mnem_s;
    dec.opcode = t_instr_opcode'(opc_s);
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.pc     = '0;
    if (mnem_s == OP_NA) begin
      dec.illegal = 1'b1;
      dec.imm     = '0;
      dec.rd_we   = 1'b0;
    end else begin
      dec.illegal = 1'b0;
      dec.imm     = imm_sel_s;
      dec.rd_we   = wr_s & (instr[11:7] != 5'd0);
    end
  end

endmodule

// File: rtl/risc_v_decode_stage.sv
// Registered RV32I decode stage: valid/ready handshake with an output register
// plus one skid entry, and a saturating count of illegal words accepted.
module risc_v_decode_stage
  import risc_v_decode_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = 10,
  parameter int SUPPORT_U = 1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  risc_v_decode_stage_if.slave  bus
);

  t_decoded             dec_raw_s, dec_s;
  t_decoded             out_d, out_q, skid_d, skid_q;
  logic                 out_valid_d, out_valid_q;
  logic                 skid_valid_d, skid_valid_q;
  logic                 in_ready_d, in_ready_q;
  logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;
  logic                 in_acc_s, out_free_s;
  logic                 unused_s;

  risc_v_decoder_comb #(.SUPPORT_U(SUPPORT_U)) u_decoder (
    .instr (bus.in_instr),
    .dec   (dec_raw_s)
  );

  // Attach the PC to the decoded word.
  always_comb begin
    dec_s               = dec_raw_s;
    dec_s.pc            = '0;
    dec_s.pc[PC_W-1:0]  = bus.in_pc;
  end

  assign in_acc_s   = bus.in_valid & in_ready_q;
  assign out_free_s = ~out_valid_q | bus.out_ready;

  // Output/skid steering: the skid entry always drains ahead of new input to keep order.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free_s) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_acc_s) begin
        out_d       = dec_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (in_acc_s) begin
        skid_d       = dec_s;
        skid_valid_d = 1'b1;
      end else begin
        skid_d = skid_q;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  // Saturating illegal-word counter, counted at input acceptance.
  always_comb begin
    if (in_acc_s && dec_s.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end else begin
      ill_cnt_d = ill_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      ill_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_mnem    = out_q.mnem;
  assign bus.out_opcode  = out_q.opcode;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_imm     = out_q.imm[XLEN-1:0];
  assign bus.out_rd_we   = out_q.rd_we;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_pc      = out_q.pc[PC_W-1:0];
  assign bus.ill_count   = ill_cnt_q;

  // Upper imm/pc bits beyond XLEN/PC_W are intentionally dropped.
  assign unused_s = ^{out_q.imm, out_q.pc, dec_raw_s.pc};

endmodule

// File: tb/tb_risc_v_decode_stage.sv
// Directed bench for risc_v_decode_stage: decode vectors, skid ordering under
// backpressure, illegal counter saturation and asynchronous reset.
module tb_risc_v_decode_stage;
  import risc_v_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  risc_v_decode_stage_if #(.XLEN(32), .PC_W(10), .ILL_CNT_W(8)) bus ();
  risc_v_decode_stage_if #(.XLEN(32), .PC_W(10), .ILL_CNT_W(8)) bus2 ();

  risc_v_decode_stage #(.XLEN(32), .PC_W(10), .SUPPORT_U(1), .ILL_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  risc_v_decode_stage #(.XLEN(32), .PC_W(10), .SUPPORT_U(0), .ILL_CNT_W(8)) dut_nou (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word for one cycle, then check the registered result.
  task automatic step(input string tag, input logic [31:0] ins, input logic [9:0] pc,
                      input t_instr_mnemonic em, input logic [31:0] eimm,
                      input logic ewe, input logic eill);
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_valid"},   64'(bus.out_valid),   64'd1);
    chk({tag, "_mnem"},    64'(bus.out_mnem),    64'(em));
    chk({tag, "_imm"},     64'(bus.out_imm),     64'(eimm));
    chk({tag, "_rd_we"},   64'(bus.out_rd_we),   64'(ewe));
    chk({tag, "_illegal"}, 64'(bus.out_illegal), 64'(eill));
    chk({tag, "_pc"},      64'(bus.out_pc),      64'(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   i, j, n_acc, n_drain, n_ok;
    logic saw_stall;

    bus.in_valid   = 1'b0; bus.in_instr  = 32'h0; bus.in_pc  = 10'h0; bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0; bus2.in_instr = 32'h0; bus2.in_pc = 10'h0; bus2.out_ready = 1'b1;

    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_ill_count", 64'(bus.ill_count), 64'd0);
    chk("rst_mnem",      64'(bus.out_mnem),  64'(OP_NA));
    chk("rst_imm",       64'(bus.out_imm),   64'd0);
    chk("rst_rd_we",     64'(bus.out_rd_we), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    step("add", 32'h002081B3, 10'h004, OP_ADD, 32'h0, 1'b1, 1'b0);
    chk("add_rd",     64'(bus.out_rd),     64'd3);
    chk("add_rs1",    64'(bus.out_rs1),    64'd1);
    chk("add_rs2",    64'(bus.out_rs2),    64'd2);
    chk("add_opcode", 64'(bus.out_opcode), 64'(OPC_OP));
    step("addi", 32'hFFF00293, 10'h008, OP_ADDI, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("addi_rd", 64'(bus.out_rd), 64'd5);
    step("beq",   32'hFE208EE3, 10'h00C, OP_BEQ,   32'hFFFFFFFC, 1'b0, 1'b0);
    step("lui",   32'h123450B7, 10'h010, OP_LUI,   32'h12345000, 1'b1, 1'b0);
    chk("lui_rd", 64'(bus.out_rd), 64'd1);
    step("auipc", 32'h80000117, 10'h014, OP_AUIPC, 32'h80000000, 1'b1, 1'b0);
    step("sw",    32'h0020A223, 10'h018, OP_SW,    32'h00000004, 1'b0, 1'b0);
    step("jal",   32'hFFDFF0EF, 10'h01C, OP_JAL,   32'hFFFFFFFC, 1'b1, 1'b0);
    step("jal_x0", 32'h0000006F, 10'h020, OP_JAL,  32'h0,        1'b0, 1'b0);
    step("srai",  32'h4030D093, 10'h024, OP_SRAI,  32'h00000403, 1'b1, 1'b0);
    step("slli_bad_f7", 32'h40309093, 10'h028, OP_NA, 32'h0, 1'b0, 1'b1);
    step("ecall", 32'h00000073, 10'h02C, OP_ECALL, 32'h0, 1'b0, 1'b0);
    step("jalr_bad_f3", 32'h000090E7, 10'h030, OP_NA, 32'h0, 1'b0, 1'b1);
    step("bad_opcode",  32'hFFFFFFFF, 10'h3FF, OP_NA, 32'h0, 1'b0, 1'b1);
    chk("ill_count_3", 64'(bus.ill_count), 64'd3);

    // LUI on the instance built without U-type support.
    bus2.in_instr = 32'h123450B7;
    bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk("nou_valid",   64'(bus2.out_valid),   64'd1);
    chk("nou_mnem",    64'(bus2.out_mnem),    64'(OP_NA));
    chk("nou_illegal", 64'(bus2.out_illegal), 64'd1);
    chk("nou_rd_we",   64'(bus2.out_rd_we),   64'd0);
    chk("nou_imm",     64'(bus2.out_imm),     64'd0);
    chk("nou_ill_cnt", 64'(bus2.ill_count),   64'd1);

    // Five ADDI x(k),x0,k words with the sink stalled on cycles 2..4.
    i = 0; j = 0; saw_stall = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = !(c >= 2 && c <= 4);
      bus.in_valid  = (i < 5);
      bus.in_instr  = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
      if (!bus.in_ready) saw_stall = 1'b1;
      if (c == 3 || c == 4) begin
        chk("stall_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_hold_imm",   64'(bus.out_imm),   64'd2);
      end
      if (bus.out_valid && bus.out_ready) begin
        j++;
        chk("stream_order", 64'(bus.out_imm), 64'(j));
      end
      if (bus.in_valid && bus.in_ready) i++;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count",   64'(j),         64'd5);
    chk("stream_stalled", 64'(saw_stall), 64'd1);

    // 300 all-zero words: every one illegal, counter saturates.
    n_acc = 0; n_drain = 0; n_ok = 0;
    bus.in_instr = 32'h0;
    for (int c = 0; c < 400 && n_drain < 300; c++) begin
      bus.in_valid = (n_acc < 300);
      if (bus.out_valid && bus.out_ready) begin
        n_drain++;
        if (bus.out_mnem == OP_NA && bus.out_illegal && !bus.out_rd_we) n_ok++;
      end
      if (bus.in_valid && bus.in_ready) n_acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("sat_drained",     64'(n_drain),       64'd300);
    chk("sat_all_illegal", 64'(n_ok),          64'd300);
    chk("sat_count",       64'(bus.ill_count), 64'd255);

    // Reset in the middle of a stream.
    bus.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ill_count", 64'(bus.ill_count), 64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_mnem",      64'(bus.out_mnem),  64'(OP_NA));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    step("post_rst_add", 32'h002081B3, 10'h100, OP_ADD, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
